// File: rtl/latency_credit_sink.sv
// rtl/latency_credit_sink.sv - credit-gated result FIFO for a fixed-latency pipelined unit
// Issue is throttled by credits; results land in a circular FIFO and a return-time tracker flags latency slips.
module latency_credit_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4,
  parameter int DEPTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  pipe_en,
  input  logic                  pipe_valid,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  err_overflow,
  output logic                  err_latency
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [CW-1:0]         credits;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LATENCY-1:0]    tracker;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  pop;
  logic                  push;
  logic                  full;
  logic                  expected;

  // Handshake outputs are gated by rst so nothing leaks out while reset is held.
  always_comb begin
    full       = (count == FULL);
    ins_ready  = rst && (credits != '0);
    pipe_en    = ins_valid && ins_ready;
    outs_valid = rst && (count != '0);
    pop        = outs_valid && outs_ready;
    push       = pipe_valid && (!full || pop);
    expected   = tracker[LATENCY-1];
    outs       = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= FULL;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      case ({pipe_en, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tracker <= '0;
    end else begin
      tracker[0] <= pipe_en;
      for (int i = 1; i < LATENCY; i++) tracker[i] <= tracker[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow <= 1'b0;
      err_latency  <= 1'b0;
    end else begin
      if (pipe_valid && full && !pop) err_overflow <= 1'b1;
      if (pipe_valid != expected)     err_latency  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_latency_credit_sink.sv
// tb/tb_latency_credit_sink.sv - randomized self-checking bench for latency_credit_sink
// A queue/integer reference model predicts every handshake, data word and sticky flag each cycle.
module tb_latency_credit_sink;
  localparam int DW  = 32;
  localparam int LAT = 4;
  localparam int DEP = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic          pipe_en;
  logic          pipe_valid = 1'b0;
  logic [DW-1:0] pipe_data = '0;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready = 1'b0;
  logic          err_overflow;
  logic          err_latency;

  latency_credit_sink #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .pipe_en(pipe_en),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .err_overflow(err_overflow), .err_latency(err_latency)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } res_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            credits;
  logic [DW-1:0] q[$];
  res_t          pend[$];
  bit            issued[int];
  bit            m_ovf;
  bit            m_lat;
  bit            dead_seen = 1'b0;
  int            nissue;
  int            first_en;
  int            first_ov;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mode 0: unit returns results on time; 1: force pipe_valid with fd; 2: swallow a due result
  task automatic tick(input bit iv, input bit ordy, input int mode, input logic [DW-1:0] fd);
    bit            pv;
    logic [DW-1:0] pd;
    bit            e_rdy;
    bit            e_en;
    bit            e_ov;
    bit            pop;
    bit            exp_v;
    res_t          r;
    ins_valid  = iv;
    outs_ready = ordy;
    pv = 1'b0;
    pd = $urandom;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (mode != 2) begin
        pv = 1'b1;
        pd = r.d;
      end
    end
    if (mode == 1) begin
      pv = 1'b1;
      pd = fd;
    end
    pipe_valid = pv;
    pipe_data  = pd;
    #1;
    e_rdy = (credits > 0);
    e_en  = iv && e_rdy;
    e_ov  = (q.size() > 0);
    chk("ins_ready", ins_ready, e_rdy);
    chk("pipe_en", pipe_en, e_en);
    chk("outs_valid", outs_valid, e_ov);
    if (e_ov) chk("outs", outs, q[0]);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_latency", err_latency, m_lat);
    if (outs_valid && outs == 32'h0000_DEAD) dead_seen = 1'b1;
    pop   = e_ov && ordy;
    exp_v = issued.exists(cyc - LAT) ? issued[cyc - LAT] : 1'b0;
    if (pv != exp_v) m_lat = 1'b1;
    if (pop) void'(q.pop_front());
    if (pv) begin
      if (q.size() < DEP) q.push_back(pd);
      else m_ovf = 1'b1;
    end
    credits = credits + (pop ? 1 : 0) - (e_en ? 1 : 0);
    issued[cyc] = e_en;
    if (e_en) begin
      r.due = cyc + LAT;
      r.d   = $urandom | 32'h8000_0000;
      pend.push_back(r);
      nissue++;
      if (first_en < 0) first_en = cyc;
    end
    if (e_ov && first_ov < 0) first_ov = cyc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    ins_valid  = 1'b1;
    pipe_valid = 1'b0;
    outs_ready = 1'b1;
    #1;
    chk("rst_ins_ready", ins_ready, 1'b0);
    chk("rst_pipe_en", pipe_en, 1'b0);
    chk("rst_outs_valid", outs_valid, 1'b0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rst_err_overflow", err_overflow, 1'b0);
    chk("rst_err_latency", err_latency, 1'b0);
    credits = DEP;
    q.delete();
    pend.delete();
    issued.delete();
    m_ovf = 1'b0;
    m_lat = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // streaming: count issues and measure first issue-to-valid distance
    nissue = 0; first_en = -1; first_ov = -1;
    for (int i = 0; i < 60 && nissue < 20; i++) tick(1'b1, 1'b1, 0, '0);
    chk("t2_issues", nissue, 20);
    chk("t2_first_latency", first_ov - first_en, LAT + 1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 0, '0);

    // reset mid-burst with three results buffered
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 0, '0);
    chk("t1_count3", q.size(), 3);
    do_reset();

    // backpressure: exactly DEPTH issues, FIFO fills, no overflow
    nissue = 0;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 0, '0);
    chk("t3_issues", nissue, DEP);
    chk("t3_full", q.size(), DEP);

    // full + forced result + pop in the same cycle
    tick(1'b0, 1'b1, 1, 32'h0000_1234);
    chk("t4_count_stays", q.size(), DEP);
    chk("t4_no_overflow", err_overflow, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 0, '0);
    do_reset();

    // overflow: full, no pop, forced result is dropped
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 0, '0);
    tick(1'b0, 1'b0, 1, 32'h0000_DEAD);
    chk("t5_err_overflow", err_overflow, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 0, '0);
    chk("t5_overflow_sticky", err_overflow, 1'b1);
    do_reset();

    // result returns one cycle early
    tick(1'b1, 1'b1, 0, '0);
    tick(1'b0, 1'b1, 0, '0);
    tick(1'b0, 1'b1, 0, '0);
    tick(1'b0, 1'b1, 1, 32'h8000_0042);
    tick(1'b0, 1'b1, 2, '0);
    chk("t6_err_latency", err_latency, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 0, '0);
    chk("t6_latency_sticky", err_latency, 1'b1);
    do_reset();
    chk("t6_cleared", err_latency, 1'b0);

    // randomized legal traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      tick($urandom_range(0, 3) != 0,
           (i < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), 0, '0);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 0, '0);
    chk("rand_drained", outs_valid, 1'b0);
    chk("rand_no_overflow", err_overflow, 1'b0);
    chk("rand_no_latency", err_latency, 1'b0);
    chk("dead_never_on_outs", dead_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
